// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-sampled sticky pending bits, software enable mask,
// fixed lowest-index-wins priority and a request/ack/eret handshake with the CPU
// that keeps at most one interrupt in flight.
module interrupt_controller #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   int_src,
    input  logic           mask_we,
    input  logic [N-1:0]   mask_wdata,
    input  logic           int_ack,
    input  logic           int_eret,
    output logic           int_req,
    output logic [IDW-1:0] int_id,
    output logic           in_service,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   mask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_state_next;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] w_id_next;
    logic           r_req;
    logic           r_in_service;
    logic [N-1:0]   r_src_d;
    logic           r_armed;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   w_pending_next;
    logic [N-1:0]   r_mask;
    logic [N-1:0]   w_rise;
    logic [N-1:0]   w_eligible;
    logic [N-1:0]   w_clr;
    logic [IDW-1:0] w_sel;
    logic           w_any;
    logic           w_ack_take;

    // r_armed stays low for the first cycle after reset so a line already high
    // at release only loads r_src_d and never registers as a rise.
    assign w_rise     = r_armed ? (int_src & ~r_src_d) : '0;
    assign w_eligible = r_pending & r_mask;
    assign w_any      = |w_eligible;
    assign w_ack_take = (r_state == S_REQUEST) && int_ack;
    assign w_clr      = w_ack_take ? (ONE_HOT_LSB << r_id) : '0;

    // Per-bit pending update: a rise in the same cycle as its clear keeps the bit set.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pending
            assign w_pending_next[gi] = (r_pending[gi] & ~w_clr[gi]) | w_rise[gi];
        end
    endgenerate

    // Priority encoder: scan from the top so the lowest eligible index wins.
    always_comb begin
        w_sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel = IDW'(i);
            end
        end
    end

    // Edge-detect history, sticky pending bits and the software mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_d   <= '0;
            r_armed   <= 1'b0;
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_src_d   <= int_src;
            r_armed   <= 1'b1;
            r_pending <= w_pending_next;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    // Handshake next-state logic; the id is captured only when leaving IDLE.
    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_REQUEST;
                    w_id_next    = w_sel;
                end
            end
            S_REQUEST: begin
                if (int_ack) begin
                    w_state_next = S_SERVICE;
                end else if (!w_eligible[r_id]) begin
                    w_state_next = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (int_eret) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register with registered request/service flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_id         <= '0;
            r_req        <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_id         <= w_id_next;
            r_req        <= (w_state_next == S_REQUEST);
            r_in_service <= (w_state_next == S_SERVICE);
        end
    end

    assign int_req    = r_req;
    assign int_id     = r_id;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign mask       = r_mask;

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios followed by random
// traffic, checked by a transaction-level reference model and a request scoreboard.
module tb_interrupt_controller;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   int_src = '0;
    logic           mask_we = 1'b0;
    logic [N-1:0]   mask_wdata = '0;
    logic           int_ack = 1'b0;
    logic           int_eret = 1'b0;
    logic           int_req;
    logic [IDW-1:0] int_id;
    logic           in_service;
    logic [N-1:0]   pending;
    logic [N-1:0]   mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_controller #(.N(N), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .int_src    (int_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .int_eret   (int_eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: who is waiting, who is being offered, who is being served.
    logic [N-1:0]   m_pend;
    logic [N-1:0]   m_mask;
    logic [N-1:0]   m_prev;
    bit             m_armed;
    int             m_phase;   // 0 nothing offered, 1 offered to CPU, 2 CPU in handler
    logic [IDW-1:0] m_id;
    int             exp_q[$];
    bit             mon_en = 1'b0;

    always @(posedge clk) begin : model
        logic [N-1:0] rise;
        logic [N-1:0] elig;
        logic [N-1:0] clr;
        if (rst) begin
            m_pend  = '0;
            m_mask  = '1;
            m_prev  = '0;
            m_armed = 1'b0;
            m_phase = 0;
            m_id    = '0;
            mon_en  = 1'b1;
        end else begin
            rise    = m_armed ? (int_src & ~m_prev) : '0;
            m_prev  = int_src;
            m_armed = 1'b1;
            elig    = m_pend & m_mask;
            clr     = '0;
            if (m_phase == 0) begin
                if (elig != 0) begin
                    m_id    = IDW'(lowest(elig));
                    m_phase = 1;
                    exp_q.push_back(int'(m_id));
                end
            end else if (m_phase == 1) begin
                if (int_ack) begin
                    m_phase   = 2;
                    clr[m_id] = 1'b1;
                end else if (!elig[m_id]) begin
                    m_phase = 0;
                end
            end else if (int_eret) begin
                m_phase = 0;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    // Monitor: every new request pops the scoreboard; state is compared every cycle.
    bit prev_req = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (int_req === 1'b1 && !prev_req) begin
                chk("req_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("req_id", 32'(int_id), 32'(exp_q.pop_front()));
                end
            end
            prev_req = (int_req === 1'b1);
            chk("mon_int_req", 32'(int_req), 32'(m_phase == 1));
            chk("mon_in_service", 32'(in_service), 32'(m_phase == 2));
            chk("mon_int_id", 32'(int_id), 32'(m_id));
            chk("mon_pending", 32'(pending), 32'(m_pend));
            chk("mon_mask", 32'(mask), 32'(m_mask));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_src(input logic [N-1:0] v);
        int_src = v;
        tick();
        int_src = '0;
    endtask

    task automatic ack_eret();
        int_ack = 1'b1;
        tick();
        int_ack  = 1'b0;
        int_eret = 1'b1;
        tick();
        int_eret = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req", 32'(int_req), 32'd0);
        chk("rst_id", 32'(int_id), 32'd0);
        chk("rst_svc", 32'(in_service), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_mask", 32'(mask), 32'hF);
        rst = 1'b0;
        tick();

        // Single source: request two edges after the sampled rise
        pulse_src(4'b0010);
        chk("single_pend", 32'(pending), 32'h2);
        chk("single_req_early", 32'(int_req), 32'd0);
        tick();
        chk("single_req", 32'(int_req), 32'd1);
        chk("single_id", 32'(int_id), 32'd1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("single_svc", 32'(in_service), 32'd1);
        chk("single_req_drop", 32'(int_req), 32'd0);
        chk("single_pend_clr", 32'(pending), 32'd0);
        int_eret = 1'b1;
        tick();
        int_eret = 1'b0;
        chk("single_eret", 32'(in_service), 32'd0);
        tick();
        chk("single_no_req", 32'(int_req), 32'd0);

        // Priority and freeze
        pulse_src(4'b1010);
        tick();
        chk("prio_id1", 32'(int_id), 32'd1);
        pulse_src(4'b0001);
        tick();
        chk("freeze_req", 32'(int_req), 32'd1);
        chk("freeze_id", 32'(int_id), 32'd1);
        chk("freeze_pend", 32'(pending), 32'hB);
        ack_eret();
        tick();
        chk("prio_next_req", 32'(int_req), 32'd1);
        chk("prio_next_id0", 32'(int_id), 32'd0);
        ack_eret();
        tick();
        chk("prio_last_id3", 32'(int_id), 32'd3);
        ack_eret();
        tick();

        // Mask blocks requests but not pending
        write_mask(4'b1110);
        pulse_src(4'b0001);
        tick();
        tick();
        chk("mask_pend", 32'(pending), 32'h1);
        chk("mask_no_req", 32'(int_req), 32'd0);
        write_mask(4'b1111);
        tick();
        chk("unmask_req", 32'(int_req), 32'd1);
        chk("unmask_id", 32'(int_id), 32'd0);
        ack_eret();
        tick();

        // Withdraw when software masks the requested source
        pulse_src(4'b0100);
        tick();
        chk("wd_req", 32'(int_req), 32'd1);
        chk("wd_id", 32'(int_id), 32'd2);
        write_mask(4'b1011);
        tick();
        chk("wd_req_drop", 32'(int_req), 32'd0);
        chk("wd_svc", 32'(in_service), 32'd0);
        chk("wd_pend_kept", 32'(pending), 32'h4);
        write_mask(4'b1111);
        tick();
        chk("wd_rereq_id", 32'(int_id), 32'd2);
        ack_eret();
        tick();

        // Rise during clear keeps the pending bit
        pulse_src(4'b0100);
        tick();
        int_ack = 1'b1;
        int_src = 4'b0100;
        tick();
        int_ack = 1'b0;
        int_src = '0;
        chk("rdc_pend", 32'(pending), 32'h4);
        chk("rdc_svc", 32'(in_service), 32'd1);
        int_eret = 1'b1;
        tick();
        int_eret = 1'b0;
        tick();
        chk("rdc_rereq", 32'(int_req), 32'd1);
        chk("rdc_id", 32'(int_id), 32'd2);
        ack_eret();
        tick();

        // Reset in SERVICE with a line held high
        int_src = 4'b0010;
        tick();
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("rmid_svc", 32'(in_service), 32'd1);
        rst = 1'b1;
        tick();
        chk("rmid_req", 32'(int_req), 32'd0);
        chk("rmid_svc0", 32'(in_service), 32'd0);
        chk("rmid_id", 32'(int_id), 32'd0);
        chk("rmid_pend", 32'(pending), 32'd0);
        chk("rmid_mask", 32'(mask), 32'hF);
        rst = 1'b0;
        repeat (3) tick();
        chk("rmid_held_noreq", 32'(int_req), 32'd0);
        chk("rmid_held_nopend", 32'(pending), 32'd0);
        int_src = '0;
        tick();
        pulse_src(4'b0010);
        tick();
        chk("rmid_new_req", 32'(int_req), 32'd1);
        chk("rmid_new_id", 32'(int_id), 32'd1);
        ack_eret();
        tick();

        // Spurious handshakes in IDLE
        int_ack  = 1'b1;
        int_eret = 1'b1;
        tick();
        int_ack  = 1'b0;
        int_eret = 1'b0;
        tick();
        chk("spur_req", 32'(int_req), 32'd0);
        chk("spur_svc", 32'(in_service), 32'd0);
        chk("spur_id", 32'(int_id), 32'd1);
        chk("spur_pend", 32'(pending), 32'd0);

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            int_src    = N'($urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(0, 19) == 0);
            mask_wdata = N'($urandom | $urandom);
            int_ack    = ($urandom_range(0, 2) == 0);
            int_eret   = ($urandom_range(0, 3) == 0);
            tick();
        end
        int_src  = '0;
        mask_we  = 1'b0;
        int_ack  = 1'b0;
        int_eret = 1'b0;
        rst      = 1'b1;
        tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
